// File: rtl/cube_frame_packer_pkg.sv
// Shared types, cube geometry and slot mapping for the cube frame packer.
package cube_pkg;

  typedef logic [0:3] nib_t;

  localparam int I_LO  = 3;
  localparam int I_HI  = 4;
  localparam int J_LO  = 2;
  localparam int J_HI  = 4;
  localparam int NSLOT = 6;

  typedef logic [2:0] slot_t;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, HOLD} state_t;

  typedef struct packed {
    int i;
    int j;
  } ij_t;

  // Slots fill the cube row by row, three columns per row.
  function automatic ij_t slot_to_ij(input int k);
    ij_t r;
    r.i = I_LO + k / (J_HI - J_LO + 1);
    r.j = J_LO + k % (J_HI - J_LO + 1);
    return r;
  endfunction

endpackage

// File: rtl/cube_frame_packer_if.sv
// Beat input stream and cube output stream of the cube frame packer.
interface cube_frame_packer_if;
  import cube_pkg::*;

  logic in_valid;
  logic in_ready;
  nib_t in_data;
  logic in_last;

  logic out_valid;
  logic out_ready;
  logic cube [I_LO:I_HI][J_LO:J_HI][0:3];
  int   frame_cnt;

  logic err_short;
  logic err_long;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, cube, frame_cnt, err_short, err_long
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, cube, frame_cnt, err_short, err_long
  );

endinterface

// File: rtl/cube_frame_packer_slot_decoder.sv
// Turns the current fill slot into a one-hot write enable and a mask of the
// slots after it (the ones a short frame pads).
module cube_slot_decoder
  import cube_pkg::*;
(
  input  slot_t             slot,
  output logic [NSLOT-1:0]  hit,
  output logic [NSLOT-1:0]  above
);

  always_comb begin
    hit   = '0;
    above = '0;
    for (int k = 0; k < NSLOT; k++) begin
      hit[k]   = (slot == slot_t'(k));
      above[k] = (slot_t'(k) > slot);
    end
  end

endmodule

// File: rtl/cube_frame_packer.sv
// Collects six 4-bit beats per frame into the 2x3 cube, flags short and long
// frames, and holds one finished frame until the consumer takes it.
module cube_frame_packer
  import cube_pkg::*;
#(
  parameter nib_t PAD_NIB    = 4'b0000,
  parameter bit   DROP_SHORT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  cube_frame_packer_if.slave bus
);

  state_t           state;
  slot_t            slot;
  nib_t             slot_q [NSLOT];
  logic             out_valid_q;
  logic             err_short_q;
  logic             err_long_q;
  int               frame_cnt_q;
  logic             in_ready;
  logic             accept;
  logic             last_slot;
  logic [NSLOT-1:0] slot_hit;
  logic [NSLOT-1:0] slot_above;

  cube_slot_decoder u_dec (
    .slot  (slot),
    .hit   (slot_hit),
    .above (slot_above)
  );

  assign in_ready  = (state != HOLD) && !rst;
  assign accept    = bus.in_valid && in_ready;
  assign last_slot = (slot == slot_t'(NSLOT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      out_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= 0;
      for (int k = 0; k < NSLOT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            // A short frame pads every slot after the one just written.
            for (int k = 0; k < NSLOT; k++) begin
              if (slot_hit[k]) begin
                slot_q[k] <= bus.in_data;
              end else if (bus.in_last && !DROP_SHORT && slot_above[k]) begin
                slot_q[k] <= PAD_NIB;
              end
            end
            if (bus.in_last) begin
              slot <= '0;
              if (last_slot) begin
                state       <= HOLD;
                out_valid_q <= 1'b1;
              end else begin
                err_short_q <= 1'b1;
                if (DROP_SHORT) begin
                  state <= IDLE;
                end else begin
                  state       <= HOLD;
                  out_valid_q <= 1'b1;
                end
              end
            end else if (last_slot) begin
              slot       <= '0;
              state      <= DRAIN;
              err_long_q <= 1'b1;
            end else begin
              slot  <= slot + 3'd1;
              state <= FILL;
            end
          end
        end
        DRAIN: begin
          if (accept && bus.in_last) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;

  for (genvar k = 0; k < NSLOT; k++) begin : g_map
    localparam ij_t IJ = slot_to_ij(k);
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign bus.cube[IJ.i][IJ.j][b] = slot_q[k][b];
    end
  end

endmodule

// File: tb/tb_cube_frame_packer.sv
// Directed bench for cube_frame_packer: a padding instance driven from a frame
// table plus hand sequences, and a dropping instance for discarded short frames.
module tb_cube_frame_packer;
  import cube_pkg::*;

  typedef struct {
    int         n;
    logic [3:0] beats [9];
    logic [3:0] exp [6];
    bit         sh;
    bit         lg;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cube_frame_packer_if b0 ();
  cube_frame_packer_if b1 ();

  cube_frame_packer #(.PAD_NIB(4'hF), .DROP_SHORT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  cube_frame_packer #(.PAD_NIB(4'h5), .DROP_SHORT(1'b1)) dut_drop (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int checks    = 0;
  int failures  = 0;
  int model_cnt = 0;

  int   short_cnt0 = 0, long_cnt0 = 0, rise_cnt0 = 0;
  int   short_cnt1 = 0, rise_cnt1 = 0;
  logic ov_prev0 = 1'b0, ov_prev1 = 1'b0;

  vec_t vecs [7];

  // Pulse and out_valid-rise counters, sampled on the quiet clock edge.
  always @(negedge clk) begin
    if (b0.err_short === 1'b1) short_cnt0 <= short_cnt0 + 1;
    if (b0.err_long === 1'b1) long_cnt0 <= long_cnt0 + 1;
    if (b0.out_valid === 1'b1 && ov_prev0 !== 1'b1) rise_cnt0 <= rise_cnt0 + 1;
    ov_prev0 <= b0.out_valid;
    if (b1.err_short === 1'b1) short_cnt1 <= short_cnt1 + 1;
    if (b1.out_valid === 1'b1 && ov_prev1 !== 1'b1) rise_cnt1 <= rise_cnt1 + 1;
    ov_prev1 <= b1.out_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] cubeVal(input bit sel, input int i, input int j);
    if (sel) return {b1.cube[i][j][0], b1.cube[i][j][1], b1.cube[i][j][2], b1.cube[i][j][3]};
    return {b0.cube[i][j][0], b0.cube[i][j][1], b0.cube[i][j][2], b0.cube[i][j][3]};
  endfunction

  function automatic logic [3:0] slotVal(input bit sel, input int k);
    return cubeVal(sel, 3 + k / 3, 2 + k % 3);
  endfunction

  // Drives one beat at a falling edge once in_ready is high; returns one cycle later.
  task automatic sendBeat(input bit sel, input logic [3:0] d, input bit last);
    int guard = 0;
    if (!(sel ? b1.in_ready : b0.in_ready)) begin
      if (sel) b1.in_valid = 1'b0; else b0.in_valid = 1'b0;
      while (!(sel ? b1.in_ready : b0.in_ready) && guard < 50) begin
        @(negedge clk);
        guard++;
      end
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    if (sel) begin
      b1.in_valid = 1'b1; b1.in_data = d; b1.in_last = last;
    end else begin
      b0.in_valid = 1'b1; b0.in_data = d; b0.in_last = last;
    end
    @(negedge clk);
  endtask

  task automatic idleInputs();
    b0.in_valid = 1'b0; b0.in_last = 1'b0;
    b1.in_valid = 1'b0; b1.in_last = 1'b0;
  endtask

  // Sends one frame with the consumer stalled, checks the held cube, then hands it off.
  task automatic applyStimulus(input vec_t v, input int idx);
    int s0, l0, r0;
    s0 = short_cnt0; l0 = long_cnt0; r0 = rise_cnt0;
    b0.out_ready = 1'b0;
    for (int k = 0; k < v.n; k++) sendBeat(1'b0, v.beats[k], (k == v.n - 1));
    idleInputs();
    checkOutput($sformatf("vec%0d_out_valid", idx), 32'(b0.out_valid), 32'd1);
    checkOutput($sformatf("vec%0d_in_ready_hold", idx), 32'(b0.in_ready), 32'd0);
    checkOutput($sformatf("vec%0d_cnt_before", idx), b0.frame_cnt, model_cnt);
    for (int k = 0; k < NSLOT; k++)
      checkOutput($sformatf("vec%0d_slot%0d", idx, k), 32'(slotVal(1'b0, k)), 32'(v.exp[k]));
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
    model_cnt++;
    checkOutput($sformatf("vec%0d_out_valid_after", idx), 32'(b0.out_valid), 32'd0);
    checkOutput($sformatf("vec%0d_cnt_after", idx), b0.frame_cnt, model_cnt);
    checkOutput($sformatf("vec%0d_err_short", idx), short_cnt0 - s0, 32'(v.sh));
    checkOutput($sformatf("vec%0d_err_long", idx), long_cnt0 - l0, 32'(v.lg));
    checkOutput($sformatf("vec%0d_frames", idx), rise_cnt0 - r0, 32'd1);
  endtask

  initial begin
    int r1, s1;

    vecs[0] = '{6, '{4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h0,4'h0,4'h0},
                   '{4'h1,4'h2,4'h3,4'h4,4'h5,4'h6}, 1'b0, 1'b0};
    vecs[1] = '{2, '{4'hA,4'hB,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0},
                   '{4'hA,4'hB,4'hF,4'hF,4'hF,4'hF}, 1'b1, 1'b0};
    vecs[2] = '{9, '{4'h7,4'h8,4'h9,4'hA,4'hB,4'hC,4'hD,4'hE,4'h1},
                   '{4'h7,4'h8,4'h9,4'hA,4'hB,4'hC}, 1'b0, 1'b1};
    vecs[3] = '{1, '{4'h5,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0},
                   '{4'h5,4'hF,4'hF,4'hF,4'hF,4'hF}, 1'b1, 1'b0};
    vecs[4] = '{5, '{4'hC,4'h0,4'hF,4'h3,4'h9,4'h0,4'h0,4'h0,4'h0},
                   '{4'hC,4'h0,4'hF,4'h3,4'h9,4'hF}, 1'b1, 1'b0};
    vecs[5] = '{7, '{4'h2,4'h4,4'h6,4'h8,4'hA,4'hC,4'hE,4'h0,4'h0},
                   '{4'h2,4'h4,4'h6,4'h8,4'hA,4'hC}, 1'b0, 1'b1};
    vecs[6] = '{6, '{4'hF,4'hE,4'hD,4'hC,4'hB,4'hA,4'h0,4'h0,4'h0},
                   '{4'hF,4'hE,4'hD,4'hC,4'hB,4'hA}, 1'b0, 1'b0};

    rst = 1'b1;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_last = 1'b0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(b0.out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(b0.in_ready), 32'd0);
    checkOutput("reset_frame_cnt", b0.frame_cnt, 32'd0);
    checkOutput("reset_err", {30'd0, b0.err_short, b0.err_long}, 32'd0);
    checkOutput("reset_slot0", 32'(slotVal(1'b0, 0)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(b0.in_ready), 32'd1);

    // Normal frame with the consumer always ready: out_valid lasts one cycle.
    b0.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) sendBeat(1'b0, 4'(k + 1), (k == 5));
    idleInputs();
    checkOutput("normal_out_valid", 32'(b0.out_valid), 32'd1);
    checkOutput("normal_cube32", 32'(cubeVal(1'b0, 3, 2)), 32'h1);
    checkOutput("normal_cube34", 32'(cubeVal(1'b0, 3, 4)), 32'h3);
    checkOutput("normal_cube42", 32'(cubeVal(1'b0, 4, 2)), 32'h4);
    checkOutput("normal_cube44", 32'(cubeVal(1'b0, 4, 4)), 32'h6);
    checkOutput("normal_cnt_before", b0.frame_cnt, 32'd0);
    @(negedge clk);
    model_cnt++;
    checkOutput("normal_out_valid_drop", 32'(b0.out_valid), 32'd0);
    checkOutput("normal_cnt_after", b0.frame_cnt, model_cnt);
    checkOutput("normal_in_ready_after", 32'(b0.in_ready), 32'd1);
    b0.out_ready = 1'b0;

    // Backpressure: frame held stable for five stalled cycles.
    for (int k = 0; k < 6; k++) sendBeat(1'b0, 4'(k + 1), (k == 5));
    idleInputs();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_out_valid", c), 32'(b0.out_valid), 32'd1);
      checkOutput($sformatf("bp%0d_in_ready", c), 32'(b0.in_ready), 32'd0);
      checkOutput($sformatf("bp%0d_cube44", c), 32'(cubeVal(1'b0, 4, 4)), 32'h6);
      checkOutput($sformatf("bp%0d_cnt", c), b0.frame_cnt, model_cnt);
      @(negedge clk);
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
    model_cnt++;
    checkOutput("bp_cnt_after", b0.frame_cnt, model_cnt);
    checkOutput("bp_out_valid_after", 32'(b0.out_valid), 32'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Dropping instance: short frame vanishes, unwritten slots keep old contents.
    r1 = rise_cnt1; s1 = short_cnt1;
    sendBeat(1'b1, 4'hA, 1'b0);
    sendBeat(1'b1, 4'hB, 1'b1);
    idleInputs();
    repeat (8) @(negedge clk);
    checkOutput("drop_err_short", short_cnt1 - s1, 32'd1);
    checkOutput("drop_no_frame", rise_cnt1 - r1, 32'd0);
    checkOutput("drop_out_valid", 32'(b1.out_valid), 32'd0);
    checkOutput("drop_cnt", b1.frame_cnt, 32'd0);
    checkOutput("drop_in_ready", 32'(b1.in_ready), 32'd1);
    checkOutput("drop_slot0", 32'(slotVal(1'b1, 0)), 32'hA);
    checkOutput("drop_slot1", 32'(slotVal(1'b1, 1)), 32'hB);
    checkOutput("drop_slot2_unpadded", 32'(slotVal(1'b1, 2)), 32'h0);
    b1.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) sendBeat(1'b1, 4'(9 - k), (k == 5));
    idleInputs();
    checkOutput("drop_full_out_valid", 32'(b1.out_valid), 32'd1);
    checkOutput("drop_full_slot5", 32'(slotVal(1'b1, 5)), 32'h4);
    @(negedge clk);
    checkOutput("drop_full_cnt", b1.frame_cnt, 32'd1);
    b1.out_ready = 1'b0;

    // Reset in the middle of a frame discards it and clears everything.
    for (int k = 0; k < 3; k++) sendBeat(1'b0, 4'(k + 7), 1'b0);
    idleInputs();
    rst = 1'b1;
    #1;
    model_cnt = 0;
    checkOutput("midrst_out_valid", 32'(b0.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(b0.in_ready), 32'd0);
    checkOutput("midrst_cnt", b0.frame_cnt, 32'd0);
    for (int k = 0; k < NSLOT; k++)
      checkOutput($sformatf("midrst_slot%0d", k), 32'(slotVal(1'b0, k)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(vecs[0], 100);

    // Frame counter wraps from all ones to zero.
    @(negedge clk);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt_q;
    @(negedge clk);
    checkOutput("wrap_preload", b0.frame_cnt, 32'hFFFF_FFFF);
    model_cnt = -1;
    applyStimulus(vecs[6], 200);
    checkOutput("wrap_zero", b0.frame_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
